// File: rtl/rf_pkg.sv
// rf_pkg: shared constants for the parametrised register file.
//   - Default geometry (RF_WIDTH_DEF x RF_DEPTH_DEF) used by rf_param_clr.
//   - Clear-engine state encoding. The states are plain localparam constants,
//     and an enum with the same encoding is provided so a checker can cast the
//     engine's debug state output to a readable name.
package rf_pkg;

  localparam int RF_WIDTH_DEF = 16;
  localparam int RF_DEPTH_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/rf_clear_seq.sv
// rf_clear_seq: bulk-clear sequencer for rf_param_clr.
// It walks a pointer over every entry, one entry per cycle, and then pulses
// done for a single cycle.
// Ports:
//   clk_i       clock (rising edge)
//   rst_ni      asynchronous active-low reset
//   clr_req_i   clear request; only looked at in IDLE
//   clr_we_o    clear-write enable towards the array (high in CLEAR)
//   clr_addr_o  entry being cleared this cycle
//   clr_busy_o  high while the engine is walking the array
//   clr_done_o  one-cycle pulse after the last entry has been cleared
//   state_o     current FSM state (debug; encoding in rf_pkg)
// Handshake: a request accepted in IDLE gives DEPTH busy cycles followed by
// one done cycle. Requests seen while busy or done are dropped, not queued.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_req_i,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o,
  output logic          clr_busy_o,
  output logic          clr_done_o,
  output logic [1:0]    state_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req_i) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (ptr_q == LAST) begin
          state_d = ST_DONE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign clr_we_o   = (state_q == ST_CLEAR);
  assign clr_addr_o = ptr_q;
  assign clr_busy_o = (state_q == ST_CLEAR);
  assign clr_done_o = (state_q == ST_DONE);
  assign state_o    = state_q;

endmodule

// File: rtl/rf_param_clr.sv
// rf_param_clr: parametrised register file. It has one synchronous write
// port, two combinational read ports, an optional hard-wired zero entry and
// a sequenced bulk clear.
// Ports:
//   clk_n          clock; all state changes on its rising edge
//   rst_n          asynchronous active-low reset (zeroes every entry)
//   WE/Waddr/WData write port; the write is dropped if the address is out of
//                  range, if the clear engine is busy, or if the target is the
//                  protected zero entry
//   Aaddr/AData    read port A (combinational; out-of-range address reads 0)
//   Baddr/BData    read port B (combinational; out-of-range address reads 0)
//   clr_req        bulk-clear request (accepted in IDLE only)
//   clr_busy       high while entries are being cleared
//   clr_done       one-cycle pulse when the clear completes
// Compile option: RF_BYPASS_EN forwards an accepted write to a read port
// that addresses the same entry in the same cycle.
module rf_param_clr
  import rf_pkg::*;
#(
  parameter  int WIDTH    = RF_WIDTH_DEF,
  parameter  int DEPTH    = RF_DEPTH_DEF,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk_n,
  input  logic             rst_n,
  input  logic             WE,
  input  logic [AW-1:0]    Waddr,
  input  logic [WIDTH-1:0] WData,
  input  logic [AW-1:0]    Aaddr,
  input  logic [AW-1:0]    Baddr,
  output logic [WIDTH-1:0] AData,
  output logic [WIDTH-1:0] BData,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic [1:0]    clr_state;
  logic          wr_ok;
  logic [WIDTH-1:0] a_stored, b_stored;

  // An address is usable when it lies inside the array and is not the
  // protected zero entry.
  function automatic logic addr_ok(input logic [AW-1:0] addr);
    logic in_range;
    in_range = ({1'b0, addr} < (AW + 1)'(DEPTH));
    return in_range && !((ZERO_REG != 0) && (addr == '0));
  endfunction

  rf_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk_i      (clk_n),
    .rst_ni     (rst_n),
    .clr_req_i  (clr_req),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .clr_busy_o (clr_busy),
    .clr_done_o (clr_done),
    .state_o    (clr_state)
  );

  assign wr_ok = WE && !clr_busy && addr_ok(Waddr);

  // Writes are blocked while the engine is busy, so the two write sources
  // never compete for the same edge.
  always_ff @(posedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem_q[Waddr] <= WData;
    end
  end

  assign a_stored = addr_ok(Aaddr) ? mem_q[Aaddr] : '0;
  assign b_stored = addr_ok(Baddr) ? mem_q[Baddr] : '0;

`ifdef RF_BYPASS_EN
  assign AData = (wr_ok && (Waddr == Aaddr)) ? WData : a_stored;
  assign BData = (wr_ok && (Waddr == Baddr)) ? WData : b_stored;
`else
  assign AData = a_stored;
  assign BData = b_stored;
`endif

  // The busy/done outputs must always agree with the engine state.
  busy_matches_state: assert property (@(posedge clk_n) disable iff (!rst_n)
    (clr_busy == (clr_state == ST_CLEAR)) && (clr_done == (clr_state == ST_DONE)));

endmodule
